// File: rtl/keypad_scan4.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces
// presses and releases over scan ticks, and reports one code per key press.
module keypad_scan4 #(
    parameter int SCAN_DIV  = 8192,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  TICK_LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_LAST  = 4'(DEB_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    row_meta, rs;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    col_idx, col_idx_nx;
    logic [1:0]    cand_row, cand_row_nx;
    logic [3:0]    deb_cnt, deb_cnt_nx;
    logic [3:0]    key_q, key_nx;
    logic          valid_q, valid_nx;
    logic          held_q, held_nx;
    logic [1:0]    low_idx;
    logic          any_low;
    logic          cand_low;
    logic [3:0]    deb_inc;

    // Synchronizer idles high so a reset never looks like a pressed key.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt <= '0;
        end else if (div_cnt == TICK_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= ST_SCAN;
            col_idx  <= 2'd0;
            cand_row <= 2'd0;
            deb_cnt  <= 4'd0;
            key_q    <= 4'h0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            col_idx  <= col_idx_nx;
            cand_row <= cand_row_nx;
            deb_cnt  <= deb_cnt_nx;
            key_q    <= key_nx;
            valid_q  <= valid_nx;
            held_q   <= held_nx;
        end
    end

    // Lowest-index pressed row wins when several rows are low together.
    always_comb begin
        low_idx = 2'd3;
        if (!rs[0]) begin
            low_idx = 2'd0;
        end else if (!rs[1]) begin
            low_idx = 2'd1;
        end else if (!rs[2]) begin
            low_idx = 2'd2;
        end
    end

    assign any_low  = (rs != 4'b1111);
    assign cand_low = ~rs[cand_row];
    assign deb_inc  = deb_cnt + 4'd1;

    always_comb begin
        state_nx    = state;
        col_idx_nx  = col_idx;
        cand_row_nx = cand_row;
        deb_cnt_nx  = deb_cnt;
        key_nx      = key_q;
        valid_nx    = 1'b0;
        held_nx     = held_q;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (!any_low) begin
                        col_idx_nx = col_idx + 2'd1;
                    end else begin
                        cand_row_nx = low_idx;
                        deb_cnt_nx  = 4'd1;
                        if (DEB_SCANS == 1) begin
                            key_nx   = {low_idx, col_idx};
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                            state_nx = ST_PRESSED;
                        end else begin
                            state_nx = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (cand_low) begin
                        deb_cnt_nx = deb_inc;
                        if (deb_inc >= DEB_LAST) begin
                            key_nx   = {cand_row, col_idx};
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                            state_nx = ST_PRESSED;
                        end
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                        state_nx   = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (!cand_low) begin
                        deb_cnt_nx = 4'd1;
                        if (DEB_SCANS == 1) begin
                            held_nx    = 1'b0;
                            col_idx_nx = col_idx + 2'd1;
                            state_nx   = ST_SCAN;
                        end else begin
                            state_nx = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!cand_low) begin
                        deb_cnt_nx = deb_inc;
                        if (deb_inc >= DEB_LAST) begin
                            held_nx    = 1'b0;
                            col_idx_nx = col_idx + 2'd1;
                            state_nx   = ST_SCAN;
                        end
                    end else begin
                        state_nx = ST_PRESSED;
                    end
                end
                default: begin
                    state_nx = ST_SCAN;
                end
            endcase
        end
    end

    always_comb begin
        col       = ~(4'b0001 << col_idx);
        key       = key_q;
        key_valid = valid_q;
        key_held  = held_q;
    end

endmodule
